// File: rtl/aes_pkg.sv
// AES byte tables, state permutations and stage FSM encoding
// shared by the round-stage modules.
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } stage_state_e;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // byte (r,c) sits at bit 127-8*(4c+r) in the column-major state
  function automatic state_t shift_rows(state_t s);
    state_t res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return res;
  endfunction

  function automatic state_t inv_shift_rows(state_t s);
    state_t res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Four parallel S-box (or inverse S-box) lookups on one 32-bit word.
// Purely combinational; one instance per substitution lane.
module aes_sbox_word
  import aes_pkg::*;
#(
  parameter bit INV = 1'b0
) (
  input  word_t in_word,
  output word_t out_word
);

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign out_word[8*i +: 8] = INV ? INV_SBOX[in_word[8*i +: 8]]
                                    : SBOX[in_word[8*i +: 8]];
  end

endmodule

// File: rtl/aes_sub_shift_stage.sv
// Multi-cycle SubBytes+ShiftRows stage: LANES words substituted per
// cycle through shared S-boxes, rows permuted as the result is latched.
module aes_sub_shift_stage
  import aes_pkg::*;
#(
  parameter bit INV   = 1'b0,
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int N  = 4 / ((LANES > 0) ? LANES : 1);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
    $error("aes_sub_shift_stage: LANES must be 1, 2 or 4");
  end

  stage_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        work_q, work_d;
  state_t        out_q, out_d;
  logic          valid_q, valid_d;

  word_t      work_w   [4];
  word_t      sub_w    [4];
  word_t      lane_in  [LANES];
  word_t      lane_out [LANES];
  logic [1:0] lane_idx [LANES];
  state_t     sub_s;
  logic       accept;

  for (genvar i = 0; i < 4; i++) begin : g_word
    assign work_w[i]              = work_q[127-32*i -: 32];
    assign sub_s[127-32*i -: 32]  = sub_w[i];
  end

  // group cnt covers words cnt*LANES .. cnt*LANES+LANES-1
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l] = 2'(32'(cnt_q) * LANES + l);
    assign lane_in[l]  = work_w[lane_idx[l]];
    aes_sbox_word #(
      .INV(INV)
    ) u_sbox (
      .in_word (lane_in[l]),
      .out_word(lane_out[l])
    );
  end

  always_comb begin
    sub_w = work_w;
    for (int l = 0; l < LANES; l++) begin
      sub_w[lane_idx[l]] = lane_out[l];
    end
  end

  assign in_ready = (state_q == IDLE) ||
                    (state_q == DONE && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    out_d   = out_q;
    valid_d = valid_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (accept) begin
          work_d  = in_data;
          cnt_d   = '0;
          state_d = SUB;
        end
      end
      (state_q == SUB): begin
        work_d = sub_s;
        if (cnt_q == LAST) begin
          out_d   = INV ? inv_shift_rows(sub_s)
                        : shift_rows(sub_s);
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      (state_q == DONE): begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (in_valid) begin
            work_d  = in_data;
            cnt_d   = '0;
            state_d = SUB;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = out_q;

endmodule

// File: tb/tb_aes_sub_shift_stage.sv
// Bench for aes_sub_shift_stage: all INV/LANES configurations in
// parallel against an S-box model derived from GF(2^8) inversion.
module tb_aes_sub_shift_stage;

  localparam logic [127:0] VA = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] VB = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam int NBLK = 1700;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_chk    = 0;
  int done_cnt = 0;

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  // multiplicative inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, x);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3)
             ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s,
                                    input int r, input int c);
    return s[127-8*(4*c+r) -: 8];
  endfunction

  // out(r,c) = S(in(r,c+r)) forward, S^-1(in(r,c-r)) inverse
  function automatic logic [127:0] model(input bit inv,
                                         input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127-8*(4*c+r) -: 8] = inv ? isb[gb(s, r, (c - r + 4) % 4)]
                                      : sb[gb(s, r, (c + r) % 4)];
      end
    end
    return res;
  endfunction

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  initial begin
    logic [127:0] x;
    for (int i = 0; i < 256; i++) begin
      sb[i] = sbox_calc(8'(i));
      isb[sb[i]] = 8'(i);
    end
    check("model sbox00", {120'd0, sb[0]}, 128'h63);
    check("model sboxff", {120'd0, sb[255]}, 128'h16);
    check("model sbox53", {120'd0, sb[8'h53]}, 128'hed);
    check("model fwd fips", model(1'b0, VA), VB);
    check("model inv fips", model(1'b1, VB), VA);
    for (int i = 0; i < 4; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      check("model chain", model(1'b1, model(1'b0, x)), x);
    end
  end

  for (genvar K = 0; K < 6; K++) begin : g_cfg
    localparam bit INV   = (K >= 3);
    localparam int LANES = (K % 3 == 0) ? 1 : ((K % 3 == 1) ? 2 : 4);
    localparam int N     = 4 / LANES;

    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_data   = '0;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] out_data;
    logic [127:0] q [$];

    aes_sub_shift_stage #(
      .INV  (INV),
      .LANES(LANES)
    ) dut (
      .clk      (clk),
      .reset_n  (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data)
    );

    // compare process: every accept is modelled, every handshake checked
    initial begin
      logic         stall;
      logic [127:0] held;
      logic [127:0] e;
      stall = 1'b0;
      held  = '0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          q.delete();
          stall = 1'b0;
        end else begin
          if (stall) begin
            check($sformatf("c%0d hold data", K), out_data, held);
            check($sformatf("c%0d hold valid", K), 128'(out_valid), 128'd1);
          end
          if (in_valid && in_ready) q.push_back(model(INV, in_data));
          if (out_valid && out_ready) begin
            if (q.size() == 0) begin
              n_chk++;
              $display("FAIL c%0d spurious out: got %h expected none",
                       K, out_data);
            end else begin
              e = q.pop_front();
              check($sformatf("c%0d out", K), out_data, e);
            end
          end
          stall = out_valid && !out_ready;
          held  = out_data;
        end
      end
    end

    task automatic send(input logic [127:0] d);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        if (in_ready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        n_chk++;
        $display("FAIL c%0d send: in_ready got 0 expected 1", K);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
    endtask

    task automatic wait_out();
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        if (out_valid) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        n_chk++;
        $display("FAIL c%0d wait_out: out_valid got 0 expected 1", K);
      end
    endtask

    initial begin
      logic [127:0] vin, vout, x;
      logic [127:0] ins [3];
      logic [127:0] outs [3];
      int tout [3];
      int nout, idx, acc_n;
      bit acc;

      vin  = INV ? VB : VA;
      vout = INV ? VA : VB;
      ins[0]  = vin;
      outs[0] = vout;
      ins[1]  = INV ? {16{8'h63}} : '0;
      outs[1] = INV ? '0 : {16{8'h63}};
      ins[2]  = INV ? {16{8'h16}} : {16{8'hff}};
      outs[2] = INV ? {16{8'hff}} : {16{8'h16}};

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check($sformatf("c%0d rst out_valid", K), 128'(out_valid), 128'd0);
      check($sformatf("c%0d rst in_ready", K), 128'(in_ready), 128'd1);
      check($sformatf("c%0d rst out_data", K), out_data, '0);

      // single block: latency, then a 20-cycle stall with garbage input
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(vin);
      for (int k = 0; k < N; k++) begin
        @(negedge clk);
        check($sformatf("c%0d sub valid", K), 128'(out_valid), 128'd0);
        check($sformatf("c%0d sub ready", K), 128'(in_ready), 128'd0);
      end
      @(negedge clk);
      check($sformatf("c%0d latency valid", K), 128'(out_valid), 128'd1);
      check($sformatf("c%0d vector", K), out_data, vout);
      for (int k = 0; k < 20; k++) begin
        @(posedge clk);
        #1;
        in_valid = 1'($urandom_range(0, 1));
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        check($sformatf("c%0d stall ready", K), 128'(in_ready), 128'd0);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check($sformatf("c%0d single hs", K), 128'(out_valid), 128'd0);
      check($sformatf("c%0d single q", K), 128'(q.size()), 128'd0);

      // back-to-back blocks with in_valid held high
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = ins[0];
      idx  = 0;
      nout = 0;
      tout = '{0, 0, 0};
      for (int c = 0; c < 40 && nout < 3; c++) begin
        @(negedge clk);
        acc = in_valid && in_ready;
        if (out_valid) begin
          if (nout < 3) begin
            check($sformatf("c%0d b2b out", K), out_data, outs[nout]);
            tout[nout] = c;
          end
          nout++;
        end
        @(posedge clk);
        #1;
        if (acc) begin
          idx++;
          if (idx < 3) in_data = ins[idx];
          else in_valid = 1'b0;
        end
      end
      in_valid = 1'b0;
      check($sformatf("c%0d b2b count", K), 128'(nout), 128'd3);
      check($sformatf("c%0d b2b period1", K),
            128'(tout[1] - tout[0]), 128'(N + 1));
      check($sformatf("c%0d b2b period2", K),
            128'(tout[2] - tout[1]), 128'(N + 1));

      // asynchronous reset one cycle into substitution
      repeat (2) @(posedge clk);
      #1;
      send(vin);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check($sformatf("c%0d arst valid", K), 128'(out_valid), 128'd0);
      check($sformatf("c%0d arst ready", K), 128'(in_ready), 128'd1);
      check($sformatf("c%0d arst data", K), out_data, '0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      send(vin);
      wait_out();
      check($sformatf("c%0d post rst", K), out_data, vout);
      @(posedge clk);
      #1;

      // random traffic; inverse configs mostly see forward outputs
      acc_n = 0;
      for (int c = 0; c < 30000 && acc_n < NBLK; c++) begin
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (acc) acc_n++;
        if (acc || !in_valid) begin
          in_valid = ($urandom_range(0, 9) < 7) && (acc_n < NBLK);
          x = {$urandom, $urandom, $urandom, $urandom};
          in_data = (INV && $urandom_range(0, 3) != 0) ? model(1'b0, x) : x;
        end
        out_ready = ($urandom_range(0, 3) != 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 50 && q.size() > 0; c++) @(negedge clk);
      check($sformatf("c%0d rand count", K), 128'(acc_n), 128'(NBLK));
      check($sformatf("c%0d drain", K), 128'(q.size()), 128'd0);
      done_cnt++;
    end
  end

  initial begin
    for (int c = 0; c < 60000 && done_cnt < 6; c++) @(posedge clk);
    if (done_cnt < 6) begin
      n_chk++;
      $display("FAIL watchdog: finished configs got %0d expected 6",
               done_cnt);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
